// File: rtl/rx_frame_fifo.sv
// Store-and-forward RX frame buffer: speculative byte writes, commit on FCS-good, rewind on error.
// Latency: commit on edge N with reader idle gives the first byte on m_valid from edge N+2.
// Backpressure: m_ready stalls the output stage; a full RAM or full frame count drops the open frame.
module rx_frame_fifo #(
  parameter int DEPTH      = 2048,
  parameter int MAX_FRAMES = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          rx_clk,
  input  logic                          rst_n,
  input  logic [7:0]                    s_data,
  input  logic                          s_wr_en,
  input  logic                          s_frame_valid,
  input  logic                          s_frame_err,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [$clog2(MAX_FRAMES):0]   frames_pending,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int FW  = $clog2(MAX_FRAMES);
  localparam int FPW = FW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Byte storage and committed-frame length queue
  logic [7:0]    mem    [DEPTH];
  logic [PW-1:0] lf_mem [MAX_FRAMES];

  // Write side state
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  cm_ptr;
  logic [PW-1:0]  frame_len;
  logic           overrun;
  logic [FW:0]    lf_wp;

  // Read side state
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  remaining;
  logic [FW:0]    lf_rp;
  logic [1:0]     state;

  // Write side combinational decode
  logic [PW-1:0]  used;
  logic           full;
  logic           wr_fire;
  logic           overrun_eff;
  logic [PW-1:0]  wr_ptr_inc;
  logic [PW-1:0]  len_inc;
  logic           fp_room;
  logic           commit;
  logic           frame_drop;

  // Read side combinational decode
  logic           lf_empty;
  logic           hs;
  logic           last_hs;
  logic           lf_pop;
  logic [PW-1:0]  rd_ptr_nxt;

  assign used        = wr_ptr - rd_ptr;
  assign full        = (used == PW'(DEPTH));
  assign wr_fire     = s_wr_en && !full && !overrun;
  assign overrun_eff = overrun || (s_wr_en && full);
  assign wr_ptr_inc  = wr_ptr + PW'(wr_fire);
  assign len_inc     = frame_len + PW'(wr_fire);

  // The frame currently being streamed still counts against frame capacity,
  // so a stalled reader cannot let more than MAX_FRAMES frames accumulate.
  assign fp_room     = (frames_pending < FPW'(MAX_FRAMES));

  // Error beats valid; a zero-length valid with no overrun does nothing.
  assign commit      = s_frame_valid && !s_frame_err && !overrun_eff &&
                       fp_room && (len_inc != '0);
  assign frame_drop  = s_frame_valid && !s_frame_err &&
                       (overrun_eff || ((len_inc != '0) && !fp_room));

  assign lf_empty    = (lf_wp == lf_rp);
  assign hs          = (state == ST_STREAM) && m_ready;
  assign last_hs     = hs && (remaining == PW'(1));
  assign lf_pop      = !lf_empty && ((state == ST_IDLE) || last_hs);
  assign rd_ptr_nxt  = rd_ptr + PW'(1);

  assign m_valid     = (state == ST_STREAM);
  assign m_last      = m_valid && (remaining == PW'(1));

  // Data RAM write port; bytes land at the speculative write pointer
  always_ff @(posedge rx_clk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= s_data;
    end
  end

  // Length queue storage; the pushed length includes a same-cycle final byte
  always_ff @(posedge rx_clk) begin
    if (commit) begin
      lf_mem[lf_wp[FW-1:0]] <= len_inc;
    end
  end

  // Speculative write pointer, commit point, running length and overrun flag
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      frame_len <= '0;
      overrun   <= 1'b0;
      lf_wp     <= '0;
    end else begin
      if (s_frame_err || frame_drop) begin
        wr_ptr    <= cm_ptr;
        frame_len <= '0;
        overrun   <= 1'b0;
      end else if (commit) begin
        wr_ptr    <= wr_ptr_inc;
        cm_ptr    <= wr_ptr_inc;
        frame_len <= '0;
        overrun   <= 1'b0;
        lf_wp     <= lf_wp + (FW+1)'(1);
      end else begin
        wr_ptr    <= wr_ptr_inc;
        frame_len <= len_inc;
        overrun   <= overrun_eff;
      end
    end
  end

  // Drop statistics: one-cycle overflow pulse and saturating counter
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= frame_drop;
      if (frame_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // Committed-but-unread frame count; commit and final read together cancel
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_pending <= '0;
    end else begin
      case ({commit, last_hs})
        2'b10:   frames_pending <= frames_pending + FPW'(1);
        2'b01:   frames_pending <= frames_pending - FPW'(1);
        default: frames_pending <= frames_pending;
      endcase
    end
  end

  // Read FSM: pop a length, prime the output register, then stream with prefetch
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      lf_rp     <= '0;
      m_data    <= '0;
    end else begin
      if (lf_pop) begin
        lf_rp <= lf_rp + (FW+1)'(1);
      end
      case (state)
        ST_IDLE: begin
          if (!lf_empty) begin
            remaining <= lf_mem[lf_rp[FW-1:0]];
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          m_data <= mem[rd_ptr[AW-1:0]];
          state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (m_ready) begin
            rd_ptr <= rd_ptr_nxt;
            if (remaining == PW'(1)) begin
              if (!lf_empty) begin
                remaining <= lf_mem[lf_rp[FW-1:0]];
                state     <= ST_FETCH;
              end else begin
                remaining <= '0;
                state     <= ST_IDLE;
              end
            end else begin
              remaining <= remaining - PW'(1);
              m_data    <= mem[rd_ptr_nxt[AW-1:0]];
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: two instances (default sizing, and DEPTH=64/MAX_FRAMES=2).
// Expected bytes are queued when a frame is sent; a negedge monitor compares every valid output.
// Directed checks cover reset values, latency, drops, capacity limits and mid-stream reset.
module tb_rx_frame_fifo;

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } exp_t;

  localparam int GOOD = 0;
  localparam int BAD  = 1;

  logic        rx_clk;
  logic        rst_n         [2];
  logic [7:0]  s_data        [2];
  logic        s_wr_en       [2];
  logic        s_frame_valid [2];
  logic        s_frame_err   [2];
  logic        m_ready       [2];

  logic [7:0]  a_m_data, b_m_data;
  logic        a_m_valid, b_m_valid;
  logic        a_m_last, b_m_last;
  logic [4:0]  a_fp;
  logic [1:0]  b_fp;
  logic [15:0] a_drop, b_drop;
  logic        a_ovf, b_ovf;

  exp_t exp_q [2][$];
  int   rdy_mode [2];
  int   ovf_cnt  [2];
  int   last_cnt [2];
  int   errors = 0;
  int   checks = 0;

  rx_frame_fifo dut_a (
    .rx_clk(rx_clk), .rst_n(rst_n[0]),
    .s_data(s_data[0]), .s_wr_en(s_wr_en[0]),
    .s_frame_valid(s_frame_valid[0]), .s_frame_err(s_frame_err[0]),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_last(a_m_last), .m_ready(m_ready[0]),
    .frames_pending(a_fp), .drop_cnt(a_drop), .overflow(a_ovf)
  );

  rx_frame_fifo #(.DEPTH(64), .MAX_FRAMES(2), .CNT_W(16)) dut_b (
    .rx_clk(rx_clk), .rst_n(rst_n[1]),
    .s_data(s_data[1]), .s_wr_en(s_wr_en[1]),
    .s_frame_valid(s_frame_valid[1]), .s_frame_err(s_frame_err[1]),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last), .m_ready(m_ready[1]),
    .frames_pending(b_fp), .drop_cnt(b_drop), .overflow(b_ovf)
  );

  function automatic logic vld(int d);
    return (d == 0) ? a_m_valid : b_m_valid;
  endfunction
  function automatic logic [7:0] dat(int d);
    return (d == 0) ? a_m_data : b_m_data;
  endfunction
  function automatic logic lst(int d);
    return (d == 0) ? a_m_last : b_m_last;
  endfunction
  function automatic logic [31:0] fp(int d);
    return (d == 0) ? 32'(a_fp) : 32'(b_fp);
  endfunction
  function automatic logic [31:0] drops(int d);
    return (d == 0) ? 32'(a_drop) : 32'(b_drop);
  endfunction
  function automatic logic ovf(int d);
    return (d == 0) ? a_ovf : b_ovf;
  endfunction

  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor: every valid cycle must show the head of the expected queue
  task automatic mon_step(int d);
    exp_t e;
    if (ovf(d)) ovf_cnt[d]++;
    if (vld(d)) begin
      checks++;
      if (exp_q[d].size() == 0) begin
        errors++;
        $display("FAIL dut%0d stray byte: got %02h last=%0b, required no output", d, dat(d), lst(d));
      end else begin
        e = exp_q[d][0];
        if (dat(d) !== e.dat || lst(d) !== e.last) begin
          errors++;
          $display("FAIL dut%0d byte: got %02h last=%0b, required %02h last=%0b",
                   d, dat(d), lst(d), e.dat, e.last);
        end
        if (m_ready[d]) begin
          if (lst(d)) last_cnt[d]++;
          void'(exp_q[d].pop_front());
        end
      end
    end
  endtask

  always @(negedge rx_clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // Consumer ready pattern: 0 = stalled, 1 = always ready, 2 = alternate every cycle
  initial begin
    m_ready[0] = 1'b0;
    m_ready[1] = 1'b0;
    forever begin
      @(posedge rx_clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        case (rdy_mode[d])
          0:       m_ready[d] = 1'b0;
          1:       m_ready[d] = 1'b1;
          default: m_ready[d] = ~m_ready[d];
        endcase
      end
    end
  end

  task automatic drive_byte(int d, logic [7:0] b, logic fv, logic fe);
    s_data[d]        = b;
    s_wr_en[d]       = 1'b1;
    s_frame_valid[d] = fv;
    s_frame_err[d]   = fe;
    @(posedge rx_clk);
    #1;
    s_wr_en[d]       = 1'b0;
    s_frame_valid[d] = 1'b0;
    s_frame_err[d]   = 1'b0;
  endtask

  task automatic send_frame(int d, int n, int start, int kind, bit expect_out);
    exp_t e;
    if (expect_out) begin
      for (int i = 0; i < n; i++) begin
        e.dat  = 8'(start + i);
        e.last = (i == n - 1);
        exp_q[d].push_back(e);
      end
    end
    for (int i = 0; i < n; i++) begin
      drive_byte(d, 8'(start + i), (kind == GOOD) && (i == n - 1), (kind == BAD) && (i == n - 1));
    end
  endtask

  task automatic wait_drain(int d, int budget, string name);
    int n = 0;
    while ((exp_q[d].size() != 0 || vld(d)) && n < budget) begin
      @(posedge rx_clk);
      #1;
      n++;
    end
    chk({name, " drain remaining"}, 32'(exp_q[d].size()), 0);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  initial begin
    int ovf0, last0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; s_data[d] = 8'h00; s_wr_en[d] = 1'b0;
      s_frame_valid[d] = 1'b0; s_frame_err[d] = 1'b0;
      rdy_mode[d] = 0; ovf_cnt[d] = 0; last_cnt[d] = 0;
    end
    idle(3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset m_valid", d), 32'(vld(d)), 0);
      chk($sformatf("dut%0d reset m_last", d), 32'(lst(d)), 0);
      chk($sformatf("dut%0d reset m_data", d), 32'(dat(d)), 0);
      chk($sformatf("dut%0d reset frames_pending", d), fp(d), 0);
      chk($sformatf("dut%0d reset drop_cnt", d), drops(d), 0);
      chk($sformatf("dut%0d reset overflow", d), 32'(ovf(d)), 0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    idle(2);

    // Errored frame is rewound; only the good 60-byte frame is delivered
    rdy_mode[0] = 1;
    send_frame(0, 20, 8'h80, BAD, 1'b0);
    send_frame(0, 60, 8'h10, GOOD, 1'b1);
    chk("err-then-good wr_ptr", 32'(dut_a.wr_ptr), 60);
    chk("err-then-good drop_cnt", drops(0), 0);
    wait_drain(0, 200, "err-then-good");
    idle(2);
    chk("err-then-good last count", 32'(last_cnt[0]), 1);
    chk("err-then-good frames_pending", fp(0), 0);
    chk("err-then-good overflow count", 32'(ovf_cnt[0]), 0);

    // 64-byte frame: first byte appears two edges after the commit edge
    send_frame(0, 64, 8'h00, GOOD, 1'b1);
    @(negedge rx_clk);
    chk("latency edge N m_valid", 32'(vld(0)), 0);
    chk("latency frames_pending", fp(0), 1);
    @(negedge rx_clk);
    chk("latency edge N+1 m_valid", 32'(vld(0)), 0);
    @(negedge rx_clk);
    chk("latency edge N+2 m_valid", 32'(vld(0)), 1);
    chk("latency edge N+2 m_data", 32'(dat(0)), 0);
    wait_drain(0, 200, "frame64");
    idle(2);
    chk("frame64 last count", 32'(last_cnt[0]), 2);
    chk("frame64 frames_pending", fp(0), 0);

    // Three back-to-back frames with an alternating consumer
    rdy_mode[0] = 2;
    send_frame(0, 64, 8'h40, GOOD, 1'b1);
    send_frame(0, 64, 8'h80, GOOD, 1'b1);
    send_frame(0, 64, 8'hC0, GOOD, 1'b1);
    wait_drain(0, 1000, "toggle");
    idle(2);
    chk("toggle last count", 32'(last_cnt[0]), 5);
    chk("toggle frames_pending", fp(0), 0);

    // Frame-count limit: third commit with two frames held is dropped
    rdy_mode[1] = 0;
    send_frame(1, 10, 8'h01, GOOD, 1'b1);
    send_frame(1, 10, 8'h21, GOOD, 1'b1);
    send_frame(1, 10, 8'h41, GOOD, 1'b0);
    idle(2);
    chk("maxframes overflow pulses", 32'(ovf_cnt[1]), 1);
    chk("maxframes drop_cnt", drops(1), 1);
    chk("maxframes frames_pending", fp(1), 2);
    rdy_mode[1] = 1;
    wait_drain(1, 200, "maxframes");
    idle(2);
    chk("maxframes drained frames_pending", fp(1), 0);
    chk("maxframes last count", 32'(last_cnt[1]), 2);

    rst_n[1] = 1'b0;
    idle(1);
    rst_n[1] = 1'b1;
    idle(1);

    // RAM overflow: second 40-byte frame overruns a 64-byte buffer and is dropped
    rdy_mode[1] = 0;
    ovf0 = ovf_cnt[1];
    last0 = last_cnt[1];
    send_frame(1, 40, 8'h00, GOOD, 1'b1);
    send_frame(1, 40, 8'h50, GOOD, 1'b0);
    idle(2);
    chk("overrun overflow pulses", 32'(ovf_cnt[1] - ovf0), 1);
    chk("overrun drop_cnt", drops(1), 1);
    send_frame(1, 24, 8'hA0, GOOD, 1'b1);
    idle(2);
    chk("overrun frames_pending", fp(1), 2);
    chk("overrun stalled m_valid", 32'(vld(1)), 1);
    rdy_mode[1] = 1;
    wait_drain(1, 300, "overrun");
    idle(2);
    chk("overrun last count", 32'(last_cnt[1] - last0), 2);
    chk("overrun drained frames_pending", fp(1), 0);

    // Reset while streaming with two frames pending
    rdy_mode[1] = 0;
    send_frame(1, 10, 8'h10, GOOD, 1'b1);
    send_frame(1, 10, 8'h20, GOOD, 1'b1);
    idle(3);
    chk("midreset pre m_valid", 32'(vld(1)), 1);
    chk("midreset pre frames_pending", fp(1), 2);
    rst_n[1] = 1'b0;
    #1;
    exp_q[1].delete();
    chk("midreset m_valid", 32'(vld(1)), 0);
    chk("midreset frames_pending", fp(1), 0);
    idle(1);
    rst_n[1] = 1'b1;
    idle(1);
    rdy_mode[1] = 1;
    send_frame(1, 12, 8'h33, GOOD, 1'b1);
    chk("postreset rd_ptr start", 32'(dut_b.rd_ptr), 0);
    wait_drain(1, 100, "postreset");
    idle(2);
    chk("postreset rd_ptr end", 32'(dut_b.rd_ptr), 12);
    chk("postreset frames_pending", fp(1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_fifo.md
Name: rx_frame_fifo

Overview:
- Store-and-forward frame buffer directly downstream of the MII MAC receiver, in the rx_clk domain.
- Accepts the MAC's byte stream (data_out/wr_en) speculatively. Commits the frame on frame_valid; rewinds and discards it on frame_err.
- Presents only complete, CRC-good frames to the UDP/IP parser on a valid/ready byte stream with an end-of-frame marker.

Parameters:
- DEPTH, 2048, data RAM depth in bytes; power of two, at least 64.
- MAX_FRAMES, 16, depth of the committed-frame length FIFO; power of two.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- rx_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  8 (byte_t)  byte from the MAC receiver.
- s_wr_en  in  1  s_data valid this cycle.
- s_frame_valid  in  1  one-cycle pulse: current frame passed FCS; commit it.
- s_frame_err  in  1  one-cycle pulse: current frame bad (MAC mismatch or CRC); discard it.
- m_data  out  8 (byte_t)  output byte.
- m_valid  out  1  m_data valid.
- m_last  out  1  m_data is the final byte of the frame.
- m_ready  in  1  consumer accepts the byte when m_valid && m_ready.
- frames_pending  out  $clog2(MAX_FRAMES)+1  committed frames not yet fully read.
- drop_cnt  out  CNT_W  saturating count of frames discarded for overflow.
- overflow  out  1  one-cycle pulse when a frame is dropped for overflow.

Behaviour:
- Reset: all pointers zero, length FIFO empty, output stage empty. Outputs: m_valid=0, m_last=0, m_data=0, frames_pending=0, drop_cnt=0, overflow=0. The input side is idle with no open frame.
- Reset mid-frame or mid-read: the partial frame and all stored frames are lost; no partial output completes.
- Pointers: wr_ptr (speculative), cm_ptr (commit point) and rd_ptr are each $clog2(DEPTH)+1 bits and wrap naturally.
- Free space: DEPTH-(wr_ptr-rd_ptr). Full when wr_ptr-rd_ptr == DEPTH.
- Frame length: a counter tracks bytes written since the last commit or drop, $clog2(DEPTH)+1 bits.
- Write on s_wr_en:
  - If not full and the frame is not overrun: write s_data at wr_ptr and increment wr_ptr and the length counter.
  - If full: set the overrun flag. The byte and all later bytes of this frame are ignored.
- Termination ordering: an s_wr_en coinciding with s_frame_valid or s_frame_err belongs to the terminating frame. It is written first (if space allows), then the commit or drop is evaluated including it.
- s_frame_valid, normal commit: requires overrun=0, length FIFO not full and length>0.
  - Push the length (including the same-cycle byte) to the length FIFO and set cm_ptr to the new wr_ptr.
  - Clear the length counter. frames_pending increments on the following edge.
- s_frame_valid with overrun=1 or length FIFO full:
  - Set wr_ptr to cm_ptr, pulse overflow for 1 cycle and increment drop_cnt (saturating at all-ones).
  - Clear overrun and the length counter.
- s_frame_valid with length 0: no-op.
- s_frame_err: set wr_ptr to cm_ptr and clear the length counter and overrun. drop_cnt is unchanged.
- Both pulses in the same cycle: s_frame_err wins.
- s_frame_err with no open frame: no-op.
- Read FSM states:
  - IDLE: length FIFO not empty → pop the length into a remaining counter → FETCH.
  - FETCH: issue a synchronous RAM read at rd_ptr → STREAM.
  - STREAM: output register holds the byte with m_valid=1. m_last=1 when remaining==1.
    - On handshake: increment rd_ptr and decrement remaining.
    - If not the last byte, the next byte appears the cycle after the handshake (prefetch permitted; one byte per cycle sustained).
    - On handshake of the last byte: decrement frames_pending, then go to FETCH if another length is queued, else IDLE.
- Latency: s_frame_valid sampled on edge N with the read side IDLE and nothing queued → m_valid=1 from edge N+2, carrying the first byte.
- Output stability: m_data and m_last are held stable while m_valid && !m_ready.
- m_valid never deasserts mid-frame without a handshake.
- Space reclaim: RAM space is freed only by reads (rd_ptr). Discarded frames reclaim space immediately through the wr_ptr rewind.
- Commit and last-byte read in the same cycle: frames_pending is net unchanged.

Test Plan:
- 64-byte frame (bytes 0x00..0x3F), s_frame_valid with the last wr_en, m_ready=1 → m_valid rises 2 cycles after commit. Output is 0x00..0x3F on consecutive cycles; m_last only on 0x3F; frames_pending goes 1 then 0.
- 20 bytes then s_frame_err, followed by a 60-byte good frame → only the 60-byte frame appears. wr_ptr equals 60 after commit; drop_cnt=0.
- DEPTH=64, m_ready=0: commit a 40-byte frame, then send a 40-byte frame with s_frame_valid → overflow pulses once and drop_cnt=1. Later a 24-byte frame commits; the reads yield the 40-byte then the 24-byte frame intact.
- Three back-to-back 64-byte frames with m_ready toggling 1,0,1,0 → every byte is delivered exactly once in order, with m_data held during stalls and exactly three m_last pulses.
- MAX_FRAMES=2, m_ready=0, three 10-byte commits → third commit dropped, overflow=1, frames_pending=2.
- Assert rst_n=0 mid-STREAM with 2 frames pending → m_valid=0 and frames_pending=0 immediately. The next committed frame reads out correctly from address 0.
